// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM state encoding and reset constants.
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } ifetch_state_t;

    localparam logic [31:0] IR_RESET_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] RESET_PC         = 32'h0000_3000;

    // Instruction fetches must be word aligned.
    function automatic logic word_aligned(input logic [1:0] lsb);
        return lsb == 2'b00;
    endfunction

endpackage

// File: rtl/ifetch_tmo.sv
// Wait-cycle counter for an outstanding instruction-memory request.
module ifetch_tmo #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned   W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [W-1:0]  LAST = W'(TIMEOUT - 1);

    logic [W-1:0] cnt;

    // Count REQ cycles without an acknowledge; restart on entry to REQ.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + 1'b1;
        end
    end

    // This un-acked cycle brings the count to TIMEOUT.
    always_comb begin
        expired = enable && (cnt == LAST);
    end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch unit: issues one memory request per fetch_go and loads IR.
module ifetch
    import cpu_pkg::*;
#(
    parameter int unsigned TIMEOUT  = 16,
    parameter logic [31:0] IR_RESET = IR_RESET_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC,
    input  logic        fetch_go,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        imem_err,
    output logic [31:0] IR,
    output logic        ir_valid,
    output logic        busy,
    output logic        fetch_err,
    output logic [31:0] fetch_cnt
);

    ifetch_state_t state_q, state_d;
    logic          drop_q, drop_d;
    logic          tmo_clear, tmo_en, tmo_expired;
    logic          latch_addr, load_ir, set_err, clr_err;
    logic          discard;

    ifetch_tmo #(.TIMEOUT(TIMEOUT)) u_tmo (
        .clk     (clk),
        .rst     (rst),
        .clear   (tmo_clear),
        .enable  (tmo_en),
        .expired (tmo_expired)
    );

    // State and drop-flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
        end
    end

    // Next-state logic and per-cycle datapath controls.
    always_comb begin
        state_d    = state_q;
        drop_d     = drop_q;
        tmo_clear  = 1'b0;
        tmo_en     = 1'b0;
        latch_addr = 1'b0;
        load_ir    = 1'b0;
        set_err    = 1'b0;
        clr_err    = 1'b0;
        // A flush coinciding with the ack still discards the returned word.
        discard    = drop_q || flush;
        case (state_q)
            ST_IDLE: begin
                if (fetch_go) begin
                    if (word_aligned(PC[1:0])) begin
                        latch_addr = 1'b1;
                        clr_err    = 1'b1;
                        tmo_clear  = 1'b1;
                        drop_d     = 1'b0;
                        state_d    = ST_REQ;
                    end else begin
                        set_err = 1'b1;
                        state_d = ST_ERR;
                    end
                end
            end
            ST_REQ: begin
                if (imem_ack) begin
                    // Ack takes priority over a simultaneous timeout.
                    if (discard) begin
                        drop_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else if (imem_err) begin
                        set_err = 1'b1;
                        state_d = ST_ERR;
                    end else begin
                        load_ir = 1'b1;
                        state_d = ST_DONE;
                    end
                end else begin
                    tmo_en = 1'b1;
                    if (tmo_expired) begin
                        drop_d = 1'b0;
                        if (discard) begin
                            state_d = ST_IDLE;
                        end else begin
                            set_err = 1'b1;
                            state_d = ST_ERR;
                        end
                    end else if (flush) begin
                        drop_d = 1'b1;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Fetch address, instruction register, error flag and completion count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            imem_addr <= '0;
            IR        <= IR_RESET;
            fetch_err <= 1'b0;
            fetch_cnt <= '0;
        end else begin
            if (latch_addr) imem_addr <= PC;
            if (load_ir) begin
                IR        <= imem_rdata;
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if (set_err) fetch_err <= 1'b1;
            else if (clr_err) fetch_err <= 1'b0;
        end
    end

    // Outputs decoded from the registered state, so reset clears them at once.
    always_comb begin
        imem_req = (state_q == ST_REQ);
        ir_valid = (state_q == ST_DONE);
        busy     = (state_q != ST_IDLE);
    end

endmodule

// File: tb/tb_ifetch.sv
// Testbench for ifetch: directed vector table, async-reset sequence, random run vs. model.
module tb_ifetch;

    localparam int unsigned TMO = 4;
    localparam logic [31:0] IRR = 32'h1357_9BDF;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] PC = '0;
    logic        fetch_go = 1'b0;
    logic        flush = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        imem_err = 1'b0;
    logic [31:0] IR;
    logic        ir_valid;
    logic        busy;
    logic        fetch_err;
    logic [31:0] fetch_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ifetch #(.TIMEOUT(TMO), .IR_RESET(IRR)) dut (
        .clk        (clk),
        .rst        (rst),
        .PC         (PC),
        .fetch_go   (fetch_go),
        .flush      (flush),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .imem_err   (imem_err),
        .IR         (IR),
        .ir_valid   (ir_valid),
        .busy       (busy),
        .fetch_err  (fetch_err),
        .fetch_cnt  (fetch_cnt)
    );

    typedef struct {
        logic        go, fl, ack, er;
        logic [31:0] pc, rd;
        logic        e_req, e_valid, e_busy, e_ferr;
        logic [31:0] e_addr, e_ir, e_cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic go, input logic fl, input logic ack, input logic er,
                               input logic [31:0] pc, input logic [31:0] rd,
                               input logic e_req, input logic e_valid, input logic e_busy,
                               input logic e_ferr, input logic [31:0] e_addr,
                               input logic [31:0] e_ir, input logic [31:0] e_cnt);
        vec_t r;
        r.go = go; r.fl = fl; r.ack = ack; r.er = er; r.pc = pc; r.rd = rd;
        r.e_req = e_req; r.e_valid = e_valid; r.e_busy = e_busy; r.e_ferr = e_ferr;
        r.e_addr = e_addr; r.e_ir = e_ir; r.e_cnt = e_cnt;
        return r;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic req, input logic [31:0] addr,
                             input logic valid, input logic bsy, input logic ferr,
                             input logic [31:0] ir, input logic [31:0] cnt);
        cmp({tag, ".imem_req"},  {31'd0, imem_req},  {31'd0, req});
        cmp({tag, ".imem_addr"}, imem_addr,          addr);
        cmp({tag, ".ir_valid"},  {31'd0, ir_valid},  {31'd0, valid});
        cmp({tag, ".busy"},      {31'd0, busy},      {31'd0, bsy});
        cmp({tag, ".fetch_err"}, {31'd0, fetch_err}, {31'd0, ferr});
        cmp({tag, ".IR"},        IR,                 ir);
        cmp({tag, ".fetch_cnt"}, fetch_cnt,          cnt);
    endtask

    task automatic apply(input logic go, input logic fl, input logic ack, input logic er,
                         input logic [31:0] pc, input logic [31:0] rd);
        fetch_go = go; flush = fl; imem_ack = ack; imem_err = er; PC = pc; imem_rdata = rd;
    endtask

    // Reference model: one outstanding fetch plus a one-cycle completion pulse.
    bit          m_pend, m_drop, m_ferr;
    int unsigned m_wait;
    int          m_pulse;      // 0 none, 1 word delivered, 2 error reported
    logic [31:0] m_addr, m_ir, m_cnt;

    function automatic void model_reset();
        m_pend = 0; m_drop = 0; m_ferr = 0; m_wait = 0; m_pulse = 0;
        m_addr = '0; m_ir = IRR; m_cnt = '0;
    endfunction

    function automatic void model_step(input logic go, input logic fl, input logic ack,
                                       input logic er, input logic [31:0] pc,
                                       input logic [31:0] rd);
        bit disc;
        if (m_pulse != 0) begin
            m_pulse = 0;
        end else if (m_pend) begin
            disc = m_drop || fl;
            if (ack) begin
                m_pend = 0;
                m_drop = 0;
                if (!disc) begin
                    if (er) begin m_ferr = 1; m_pulse = 2; end
                    else begin m_ir = rd; m_cnt = m_cnt + 1; m_pulse = 1; end
                end
            end else begin
                m_wait++;
                if (m_wait == TMO) begin
                    m_pend = 0;
                    m_drop = 0;
                    if (!disc) begin m_ferr = 1; m_pulse = 2; end
                end else if (fl) begin
                    m_drop = 1;
                end
            end
        end else if (go) begin
            if (pc % 4 == 0) begin
                m_pend = 1; m_addr = pc; m_wait = 0; m_drop = 0; m_ferr = 0;
            end else begin
                m_ferr = 1; m_pulse = 2;
            end
        end
    endfunction

    initial begin
        logic [31:0] ia;
        logic [31:0] ib;
        logic [31:0] ic;
        ia = 32'h2008_0005;
        ib = 32'h0000_1111;
        ic = 32'h5555_0000;

        //             go fl ak er pc            rd            | rq vl by fe addr          IR    cnt
        // aligned fetch with immediate ack; fetch_go in DONE ignored
        tbl.push_back(v(0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 0, 0, 32'h0,        IRR, 0));
        tbl.push_back(v(1, 0, 0, 0, 32'h3000,     32'h0,        0, 0, 0, 0, 32'h0,        IRR, 0));
        tbl.push_back(v(0, 0, 1, 0, 32'h0,        ia,           1, 0, 1, 0, 32'h3000,     IRR, 0));
        tbl.push_back(v(1, 0, 0, 0, 32'h3200,     32'h0,        0, 1, 1, 0, 32'h3000,     ia,  1));
        tbl.push_back(v(0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 0, 0, 32'h3000,     ia,  1));
        // misaligned PC; fetch_go in ERR ignored
        tbl.push_back(v(1, 0, 0, 0, 32'h3002,     32'h0,        0, 0, 0, 0, 32'h3000,     ia,  1));
        tbl.push_back(v(1, 0, 0, 0, 32'h3100,     32'h0,        0, 0, 1, 1, 32'h3000,     ia,  1));
        tbl.push_back(v(0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 0, 1, 32'h3000,     ia,  1));
        // ack with memory error
        tbl.push_back(v(1, 0, 0, 0, 32'h3004,     32'h0,        0, 0, 0, 1, 32'h3000,     ia,  1));
        tbl.push_back(v(0, 0, 1, 1, 32'h0,        32'hFFFF_FFFF,1, 0, 1, 0, 32'h3004,     ia,  1));
        tbl.push_back(v(0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 1, 1, 32'h3004,     ia,  1));
        tbl.push_back(v(0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 0, 1, 32'h3004,     ia,  1));
        // timeout after TMO request cycles; fetch_go in REQ ignored
        tbl.push_back(v(1, 0, 0, 0, 32'h3008,     32'h0,        0, 0, 0, 1, 32'h3004,     ia,  1));
        tbl.push_back(v(0, 0, 0, 0, 32'h0,        32'h0,        1, 0, 1, 0, 32'h3008,     ia,  1));
        tbl.push_back(v(1, 0, 0, 0, 32'h4000,     32'h0,        1, 0, 1, 0, 32'h3008,     ia,  1));
        tbl.push_back(v(0, 0, 0, 0, 32'h0,        32'h0,        1, 0, 1, 0, 32'h3008,     ia,  1));
        tbl.push_back(v(0, 0, 0, 0, 32'h0,        32'h0,        1, 0, 1, 0, 32'h3008,     ia,  1));
        tbl.push_back(v(0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 1, 1, 32'h3008,     ia,  1));
        // good fetch clears the error; flush in DONE and IDLE is harmless
        tbl.push_back(v(1, 0, 0, 0, 32'h300C,     32'h0,        0, 0, 0, 1, 32'h3008,     ia,  1));
        tbl.push_back(v(0, 0, 1, 0, 32'h0,        ib,           1, 0, 1, 0, 32'h300C,     ia,  1));
        tbl.push_back(v(0, 1, 0, 0, 32'h0,        32'h0,        0, 1, 1, 0, 32'h300C,     ib,  2));
        tbl.push_back(v(0, 1, 0, 0, 32'h0,        32'h0,        0, 0, 0, 0, 32'h300C,     ib,  2));
        // flush in first REQ cycle, ack three cycles later: result discarded
        tbl.push_back(v(1, 0, 0, 0, 32'h3010,     32'h0,        0, 0, 0, 0, 32'h300C,     ib,  2));
        tbl.push_back(v(0, 1, 0, 0, 32'h0,        32'h0,        1, 0, 1, 0, 32'h3010,     ib,  2));
        tbl.push_back(v(0, 0, 0, 0, 32'h0,        32'h0,        1, 0, 1, 0, 32'h3010,     ib,  2));
        tbl.push_back(v(0, 0, 0, 0, 32'h0,        32'h0,        1, 0, 1, 0, 32'h3010,     ib,  2));
        tbl.push_back(v(0, 0, 1, 0, 32'h0,        32'hAAAA_AAAA,1, 0, 1, 0, 32'h3010,     ib,  2));
        tbl.push_back(v(0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 0, 0, 32'h3010,     ib,  2));
        // ack in the final (timeout) cycle wins
        tbl.push_back(v(1, 0, 0, 0, 32'h3014,     32'h0,        0, 0, 0, 0, 32'h3010,     ib,  2));
        tbl.push_back(v(0, 0, 0, 0, 32'h0,        32'h0,        1, 0, 1, 0, 32'h3014,     ib,  2));
        tbl.push_back(v(0, 0, 0, 0, 32'h0,        32'h0,        1, 0, 1, 0, 32'h3014,     ib,  2));
        tbl.push_back(v(0, 0, 0, 0, 32'h0,        32'h0,        1, 0, 1, 0, 32'h3014,     ib,  2));
        tbl.push_back(v(0, 0, 1, 0, 32'h0,        ic,           1, 0, 1, 0, 32'h3014,     ib,  2));
        tbl.push_back(v(0, 0, 0, 0, 32'h0,        32'h0,        0, 1, 1, 0, 32'h3014,     ic,  3));
        tbl.push_back(v(0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 0, 0, 32'h3014,     ic,  3));

        #12 rst = 1'b1;

        for (int unsigned i = 0; i < tbl.size(); i++) begin
            @(posedge clk); #1;
            apply(tbl[i].go, tbl[i].fl, tbl[i].ack, tbl[i].er, tbl[i].pc, tbl[i].rd);
            @(negedge clk);
            check_all($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_valid,
                      tbl[i].e_busy, tbl[i].e_ferr, tbl[i].e_ir, tbl[i].e_cnt);
        end

        // Asynchronous reset in the middle of a request.
        @(posedge clk); #1; apply(1, 0, 0, 0, 32'h3018, 32'h0);
        @(negedge clk);
        @(posedge clk); #1; apply(0, 0, 0, 0, 32'h0, 32'h0);
        @(negedge clk);
        check_all("rst_pre", 1, 32'h3018, 0, 1, 0, ic, 3);
        #1 rst = 1'b0;
        #1 check_all("rst_async", 0, 32'h0, 0, 0, 0, IRR, 0);
        @(negedge clk); #1 rst = 1'b1;
        @(posedge clk); #1; apply(1, 0, 0, 0, 32'h301C, 32'h0);
        @(negedge clk);
        check_all("rst_idle", 0, 32'h0, 0, 0, 0, IRR, 0);
        @(posedge clk); #1; apply(0, 0, 1, 0, 32'h0, 32'h0BAD_F00D);
        @(negedge clk);
        check_all("rst_req", 1, 32'h301C, 0, 1, 0, IRR, 0);
        @(posedge clk); #1; apply(0, 0, 0, 0, 32'h0, 32'h0);
        @(negedge clk);
        check_all("rst_done", 0, 32'h301C, 1, 1, 0, 32'h0BAD_F00D, 1);

        // Randomized run against the reference model.
        #1 rst = 1'b0;
        model_reset();
        @(negedge clk); #1 rst = 1'b1;
        for (int unsigned c = 0; c < 3000; c++) begin
            logic        go, fl, ack, er;
            logic [31:0] pc, rd;
            @(posedge clk); #1;
            go  = ($urandom % 100) < 35;
            fl  = ($urandom % 100) < 8;
            ack = ($urandom % 100) < 30;
            er  = ($urandom % 100) < 20;
            pc  = $urandom & 32'hFFFF_FFFC;
            if (($urandom % 100) < 15) pc = pc | 32'($urandom_range(1, 3));
            rd  = $urandom;
            apply(go, fl, ack, er, pc, rd);
            @(negedge clk);
            check_all($sformatf("rnd%0d", c), m_pend, m_addr, m_pulse == 1,
                      m_pend || (m_pulse != 0), m_ferr, m_ir, m_cnt);
            model_step(go, fl, ack, er, pc, rd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
